// File: rtl/alink_rsp_phy_pkg.sv
// Shared constants, serializer state encoding and word framing for the ALINK responder PHY.
// Optional feature: define ALINK_RSP_PARITY_EN to append an odd-parity bit to every word.
package alink_rsp_phy_pkg;

    localparam int unsigned AlinkRspBitCyc  = 16;
    localparam int unsigned AlinkRspToutCyc = 256;
    localparam int unsigned AlinkTaskWords  = 23;

`ifdef ALINK_RSP_PARITY_EN
    localparam int unsigned RspWordBits = 33;
`else
    localparam int unsigned RspWordBits = 32;
`endif

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StGap   = 2'd2
    } ser_state_e;

    // Word as it travels on the line, MSB first; parity (if any) trails bit 0.
    function automatic logic [RspWordBits-1:0] rsp_frame(input logic [31:0] dat);
`ifdef ALINK_RSP_PARITY_EN
        return {dat, ~^dat};
`else
        return dat;
`endif
    endfunction

endpackage

// File: rtl/alink_rsp_ser.sv
// Report serializer: one word at a time, each bit a BitCyc pulse followed by a BitCyc gap.
// Word length follows ALINK_RSP_PARITY_EN through the package.
module alink_rsp_ser
    import alink_rsp_phy_pkg::*;
#(
    parameter int unsigned BitCyc = AlinkRspBitCyc
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rpt_vld_i,
    input  logic [31:0] rpt_dat_i,
    output logic        rpt_rdy_o,
    output logic        rpt_p_o,
    output logic        rpt_n_o
);

    localparam int unsigned BitW   = $clog2(RspWordBits);
    localparam int unsigned TimerW = $clog2(BitCyc + 1);

    ser_state_e             state_q, state_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic [RspWordBits-1:0] word_q, word_d;
    logic                   p_q, p_d, n_q, n_d;

    // Next state; line outputs are computed from the next state so they leave a register.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        timer_d = timer_q;
        word_d  = word_q;
        p_d     = 1'b0;
        n_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rpt_vld_i) begin
                    word_d  = rsp_frame(rpt_dat_i);
                    bit_d   = BitW'(RspWordBits - 1);
                    timer_d = '0;
                    state_d = StPulse;
                    p_d     = word_d[bit_d];
                    n_d     = ~word_d[bit_d];
                end
            end
            StPulse: begin
                if (timer_q == TimerW'(BitCyc - 1)) begin
                    timer_d = '0;
                    state_d = StGap;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                    p_d     = word_q[bit_q];
                    n_d     = ~word_q[bit_q];
                end
            end
            StGap: begin
                if (timer_q == TimerW'(BitCyc - 1)) begin
                    timer_d = '0;
                    if (bit_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        bit_d   = bit_q - BitW'(1);
                        state_d = StPulse;
                        p_d     = word_q[bit_d];
                        n_d     = ~word_q[bit_d];
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and line registers; reset drops the line to idle on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            bit_q   <= '0;
            timer_q <= '0;
            word_q  <= '0;
            p_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            timer_q <= timer_d;
            word_q  <= word_d;
            p_q     <= p_d;
            n_q     <= n_d;
        end
    end

    assign rpt_rdy_o = (state_q == StIdle);
    assign rpt_p_o   = p_q;
    assign rpt_n_o   = n_q;

endmodule

// File: rtl/alink_rsp_phy.sv
// ALINK far-end responder: task-line decoder with single-entry holding stage, plus report
// serializer. Define ALINK_RSP_PARITY_EN to carry and check a trailing odd-parity bit.
module alink_rsp_phy
    import alink_rsp_phy_pkg::*;
#(
    parameter int unsigned BitCyc    = AlinkRspBitCyc,
    parameter int unsigned ToutCyc   = AlinkRspToutCyc,
    parameter int unsigned TaskWords = AlinkTaskWords
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        line_p_i,
    input  logic        line_n_i,
    output logic        task_vld_o,
    output logic [31:0] task_dat_o,
    output logic        task_sof_o,
    output logic        task_eof_o,
    input  logic        task_rdy_i,
    input  logic        rpt_vld_i,
    input  logic [31:0] rpt_dat_i,
    output logic        rpt_rdy_o,
    output logic        rpt_p_o,
    output logic        rpt_n_o,
    output logic        err_ovf_o,
    output logic        err_sym_o
);

    localparam int unsigned CntW  = $clog2(RspWordBits);
    localparam int unsigned IdxW  = $clog2(TaskWords);
    localparam int unsigned IdleW = $clog2(ToutCyc + 1);

    logic [2:0]             p_sync_q, n_sync_q;
    logic                   rise_p_q, rise_n_q, coll_q;
    logic [RspWordBits-2:0] shift_q, shift_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IdxW-1:0]        word_idx_q, word_idx_d;
    logic [IdleW-1:0]       idle_q, idle_d;
    logic                   task_vld_q, task_vld_d, sof_q, sof_d, eof_q, eof_d;
    logic [31:0]            task_dat_q, task_dat_d;
    logic                   err_ovf_q, err_ovf_d, err_sym_q, err_sym_d;
    logic [RspWordBits-1:0] word_full;
    logic                   word_done, word_ok;

    // Two-FF synchronizer plus a third stage for edge detection; edges and collisions registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_sync_q <= '0;
            n_sync_q <= '0;
            rise_p_q <= 1'b0;
            rise_n_q <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            p_sync_q <= {p_sync_q[1:0], line_p_i};
            n_sync_q <= {n_sync_q[1:0], line_n_i};
            rise_p_q <= p_sync_q[1] & ~p_sync_q[2];
            rise_n_q <= n_sync_q[1] & ~n_sync_q[2];
            coll_q   <= p_sync_q[1] & n_sync_q[1];
        end
    end

    assign word_full = {shift_q, rise_p_q};

    // Bit assembly, idle timeout, frame position and holding stage.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_idx_d = word_idx_q;
        idle_d     = idle_q;
        task_vld_d = task_vld_q;
        task_dat_d = task_dat_q;
        sof_d      = sof_q;
        eof_d      = eof_q;
        err_ovf_d  = err_ovf_q;
        err_sym_d  = err_sym_q;
        word_done  = 1'b0;

        if (task_vld_q && task_rdy_i) begin
            task_vld_d = 1'b0;
        end

        if (coll_q || (rise_p_q && rise_n_q)) begin
            err_sym_d = 1'b1;
            bit_cnt_d = '0;
            idle_d    = '0;
        end else if (rise_p_q || rise_n_q) begin
            shift_d = word_full[RspWordBits-2:0];
            idle_d  = '0;
            if (bit_cnt_q == CntW'(RspWordBits - 1)) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CntW'(1);
            end
        end else if ((bit_cnt_q != '0) || (word_idx_q != '0)) begin
            // Abandon a stalled word/frame so the next word restarts at sof.
            if (idle_q == IdleW'(ToutCyc - 1)) begin
                bit_cnt_d  = '0;
                word_idx_d = '0;
                idle_d     = '0;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end

        word_ok = word_done;
`ifdef ALINK_RSP_PARITY_EN
        if (word_done && !(^word_full)) begin
            err_sym_d = 1'b1;
            word_ok   = 1'b0;
        end
`endif

        if (word_ok) begin
            word_idx_d = (word_idx_q == IdxW'(TaskWords - 1)) ? '0 : word_idx_q + IdxW'(1);
            if (task_vld_q && !task_rdy_i) begin
                err_ovf_d = 1'b1;
            end else begin
                task_vld_d = 1'b1;
                task_dat_d = word_full[RspWordBits-1 -: 32];
                sof_d      = (word_idx_q == '0);
                eof_d      = (word_idx_q == IdxW'(TaskWords - 1));
            end
        end
    end

    // Decoder and holding-stage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
            idle_q     <= '0;
            task_vld_q <= 1'b0;
            task_dat_q <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_sym_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            word_idx_q <= word_idx_d;
            idle_q     <= idle_d;
            task_vld_q <= task_vld_d;
            task_dat_q <= task_dat_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            err_ovf_q  <= err_ovf_d;
            err_sym_q  <= err_sym_d;
        end
    end

    assign task_vld_o = task_vld_q;
    assign task_dat_o = task_dat_q;
    assign task_sof_o = task_vld_q & sof_q;
    assign task_eof_o = task_vld_q & eof_q;
    assign err_ovf_o  = err_ovf_q;
    assign err_sym_o  = err_sym_q;

    alink_rsp_ser #(
        .BitCyc(BitCyc)
    ) u_ser (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rpt_vld_i(rpt_vld_i),
        .rpt_dat_i(rpt_dat_i),
        .rpt_rdy_o(rpt_rdy_o),
        .rpt_p_o  (rpt_p_o),
        .rpt_n_o  (rpt_n_o)
    );

endmodule

// File: tb/tb_alink_rsp_phy.sv
// Self-checking bench for alink_rsp_phy: random task words against a queue model of
// frame position, and the report waveform against a bit-time model.
module tb_alink_rsp_phy;

    localparam int BitCyc    = 16;
    localparam int ToutCyc   = 256;
    localparam int TaskWords = 23;
`ifdef ALINK_RSP_PARITY_EN
    localparam int WB = 33;
`else
    localparam int WB = 32;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        line_p, line_n, task_rdy, rpt_vld;
    logic [31:0] rpt_dat;
    logic        task_vld, task_sof, task_eof, rpt_rdy, rpt_p, rpt_n, err_ovf, err_sym;
    logic [31:0] task_dat;

    always #5 clk = ~clk;

    alink_rsp_phy #(
        .BitCyc   (BitCyc),
        .ToutCyc  (ToutCyc),
        .TaskWords(TaskWords)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .line_p_i  (line_p),
        .line_n_i  (line_n),
        .task_vld_o(task_vld),
        .task_dat_o(task_dat),
        .task_sof_o(task_sof),
        .task_eof_o(task_eof),
        .task_rdy_i(task_rdy),
        .rpt_vld_i (rpt_vld),
        .rpt_dat_i (rpt_dat),
        .rpt_rdy_o (rpt_rdy),
        .rpt_p_o   (rpt_p),
        .rpt_n_o   (rpt_n),
        .err_ovf_o (err_ovf),
        .err_sym_o (err_sym)
    );

    typedef struct {
        logic [31:0] dat;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t exp_q[$];
    int   widx;
    int   n_cmp, n_err, n_xfer;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line bit j of a word, MSB first, optional parity last.
    function automatic logic line_bit(input logic [31:0] w, input int j);
        if (j < 32) return w[31-j];
        return ~^w;
    endfunction

    function automatic void expect_word(input logic [31:0] w);
        exp_t e;
        e.dat = w;
        e.sof = (widx == 0);
        e.eof = (widx == TaskWords - 1);
        exp_q.push_back(e);
        widx = (widx + 1) % TaskWords;
    endfunction

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1;
        if (b) line_p = 1'b1;
        else line_n = 1'b1;
        repeat ($urandom_range(2, 4)) @(posedge clk);
        #1;
        line_p = 1'b0;
        line_n = 1'b0;
        repeat ($urandom_range(2, 4)) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int j = 0; j < WB; j++) send_bit(line_bit(w, j));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        check_eq("drain", exp_q.size(), 0);
    endtask

    // Every accepted task word is compared against the head of the model queue.
    always @(negedge clk) begin
        if (!rst && task_vld && task_rdy) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_xfer", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("task_dat", task_dat, e.dat);
                check_eq("task_sof", task_sof, e.sof);
                check_eq("task_eof", task_eof, e.eof);
            end
        end
    end

    initial begin
        logic [31:0] w, a, w1, w2;
        int          lat, x0, bad, len, kk, ph, j;
        logic        lb, idle, b, ep, en, er, rdy_l, rdy_l1, p1;

        n_cmp = 0; n_err = 0; n_xfer = 0; widx = 0;
        rst = 1'b1; line_p = 1'b0; line_n = 1'b0; task_rdy = 1'b1;
        rpt_vld = 1'b0; rpt_dat = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_task_vld", task_vld, 0);
        check_eq("rst_rpt_rdy", rpt_rdy, 1);
        check_eq("rst_rpt_p", rpt_p, 0);
        check_eq("rst_rpt_n", rpt_n, 0);
        check_eq("rst_err_ovf", err_ovf, 0);
        check_eq("rst_err_sym", err_sym, 0);

        // Single word, with latency of the last bit measured at the pin.
        w = 32'hA5A5_0F0F;
        expect_word(w);
        for (int i = 0; i < WB - 1; i++) send_bit(line_bit(w, i));
        lb = line_bit(w, WB - 1);
        @(posedge clk);
        #1;
        if (lb) line_p = 1'b1;
        else line_n = 1'b1;
        lat = 0;
        while (lat < 20 && !task_vld) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2) begin line_p = 1'b0; line_n = 1'b0; end
        end
        line_p = 1'b0; line_n = 1'b0;
        check_eq("vld_latency", lat, 4);
        repeat (3) @(posedge clk);
        drain();

        // Idle long enough to abandon the frame, then two full random frames.
        repeat (ToutCyc + 20) @(posedge clk);
        widx = 0;
        for (int i = 0; i < 2 * TaskWords; i++) begin
            w = $urandom;
            expect_word(w);
            send_word(w);
        end
        drain();

        // Partial word abandoned by timeout; next word is sof.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom));
        repeat (ToutCyc + 5) @(posedge clk);
        widx = 0;
        expect_word(32'h1234_5678);
        send_word(32'h1234_5678);
        drain();

        // Holding stage full: second word dropped, index still advances.
        @(negedge clk);
        check_eq("err_ovf_pre", err_ovf, 0);
        task_rdy = 1'b0;
        a = $urandom;
        expect_word(a);
        send_word(a);
        @(negedge clk);
        check_eq("hold_vld", task_vld, 1);
        check_eq("hold_dat_a", task_dat, a);
        widx = (widx + 1) % TaskWords;
        send_word($urandom);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("hold_dat_b", task_dat, a);
        check_eq("err_ovf", err_ovf, 1);
        x0 = n_xfer;
        task_rdy = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("one_xfer", n_xfer - x0, 1);
        check_eq("vld_clear", task_vld, 0);

        // P/N collision mid-word: partial word discarded, next word delivered.
        check_eq("err_sym_pre", err_sym, 0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        @(posedge clk);
        #1 line_p = 1'b1; line_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 line_p = 1'b0; line_n = 1'b0;
        repeat (5) @(posedge clk);
        w = $urandom;
        expect_word(w);
        send_word(w);
        drain();
        @(negedge clk);
        check_eq("err_sym", err_sym, 1);

        // Two back-to-back reports against a bit-time model.
        len = WB * 2 * BitCyc;
        w1 = 32'h8000_0001;
        w2 = $urandom;
        bad = 0; rdy_l = 1'bx; rdy_l1 = 1'bx; p1 = 1'bx;
        @(negedge clk);
        rpt_vld = 1'b1;
        rpt_dat = w1;
        @(posedge clk);
        #1 rpt_dat = w2;
        for (int k = 1; k <= 2 * len + 1; k++) begin
            @(negedge clk);
            if (k == len + 2) rpt_vld = 1'b0;
            idle = (k == len + 1);
            kk = (k <= len) ? k : k - len - 1;
            ph = (kk - 1) % (2 * BitCyc);
            j  = (kk - 1) / (2 * BitCyc);
            b  = line_bit((k <= len) ? w1 : w2, j);
            ep = !idle && (ph < BitCyc) && b;
            en = !idle && (ph < BitCyc) && !b;
            er = idle;
            if (rpt_p !== ep || rpt_n !== en || rpt_rdy !== er) bad++;
            if (k == 1) p1 = rpt_p;
            if (k == len) rdy_l = rpt_rdy;
            if (k == len + 1) rdy_l1 = rpt_rdy;
        end
        check_eq("rpt_wave_errs", bad, 0);
        check_eq("rpt_p_clk1", p1, 1);
        check_eq("rdy_last_gap", rdy_l, 0);
        check_eq("rdy_between", rdy_l1, 1);
        @(negedge clk);
        check_eq("rdy_after", rpt_rdy, 1);

        // Reset in the middle of a report.
        rpt_vld = 1'b1;
        rpt_dat = $urandom;
        @(posedge clk);
        #1 rpt_vld = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check_eq("rdy_busy", rpt_rdy, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_p", rpt_p, 0);
        check_eq("mid_rst_n", rpt_n, 0);
        check_eq("mid_rst_rdy", rpt_rdy, 1);
        check_eq("mid_rst_err_sym", err_sym, 0);
        check_eq("mid_rst_err_ovf", err_ovf, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
